sub_pipe: RTL and testbench



---
 rtl/sub_pipe_pkg.sv | 20 ++
 rtl/sub_pipe_stage.sv | 35 +++
 rtl/sub_pipe.sv | 86 ++++++++
 tb/tb_sub_pipe.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pipe_pkg.sv
// rtl/sub_pipe_pkg.sv - shared constants, result record and saturation limits for sub_pipe
package sub_pipe_pkg;

    localparam int MAX_STAGES    = 4;
    localparam int MAX_DATAWIDTH = 64;

    // Sized for the widest legal build; narrower instances use the low bits of diff.
    typedef struct packed {
        logic [MAX_DATAWIDTH-1:0] diff;
        logic                     borrow;
        logic                     ovf;
    } sub_res_t;

    function automatic logic [MAX_DATAWIDTH-1:0] signed_limit(input int width, input logic neg);
        logic [MAX_DATAWIDTH-1:0] w_top;
        w_top = {{(MAX_DATAWIDTH-1){1'b0}}, 1'b1} << (width - 1);
        signed_limit = neg ? w_top : (w_top - 1'b1);
    endfunction

endpackage

// File: rtl/sub_pipe_stage.sv
// rtl/sub_pipe_stage.sv - one valid/ready register slice with bubble collapse
module sub_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    // Empty slice accepts regardless of downstream, so bubbles are squeezed out.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/sub_pipe.sv
// rtl/sub_pipe.sv - pipelined a-b with borrow/overflow flags; SUB_PIPE_SAT_EN enables saturation
module sub_pipe
    import sub_pipe_pkg::*;
#(
    parameter int DATAWIDTH = 2,
    parameter int STAGES    = 1,
    parameter int SIGNED    = 0
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] diff,
    output logic                 borrow,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int MSB   = DATAWIDTH - 1;
    localparam int DEPTH = (STAGES < 1) ? 1 : ((STAGES > MAX_STAGES) ? MAX_STAGES : STAGES);

    logic [DATAWIDTH-1:0]     w_diff_raw;
    logic [DATAWIDTH-1:0]     w_diff_fin;
    logic                     w_borrow;
    logic                     w_ovf;
    sub_res_t                 w_res;
    sub_res_t                 w_out;
    logic [MAX_DATAWIDTH-1:0] w_out_diff_unused;

    logic [DEPTH:0]           w_valid;
    logic [DEPTH:0]           w_ready;
    sub_res_t                 w_data [DEPTH+1];

    always_comb begin
        w_diff_raw = a - b;
        w_borrow   = (a < b);
        w_ovf      = (SIGNED != 0) && (a[MSB] != b[MSB]) && (w_diff_raw[MSB] != a[MSB]);
`ifdef SUB_PIPE_SAT_EN
        // Flags keep reporting the raw condition; only the value is clamped.
        w_diff_fin = w_diff_raw;
        if ((SIGNED != 0) && w_ovf) begin
            w_diff_fin = DATAWIDTH'(signed_limit(DATAWIDTH, a[MSB]));
        end else if ((SIGNED == 0) && w_borrow) begin
            w_diff_fin = '0;
        end
`else
        w_diff_fin = w_diff_raw;
`endif
        w_res        = '0;
        w_res.diff   = MAX_DATAWIDTH'(w_diff_fin);
        w_res.borrow = w_borrow;
        w_res.ovf    = w_ovf;
    end

    assign w_valid[0]     = in_valid;
    assign w_data[0]      = w_res;
    assign w_ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        sub_pipe_stage #(
            .DW ($bits(sub_res_t))
        ) u_stage (
            .i_clk   (Clk),
            .i_rstn  (Rst),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_data  (w_data[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_data  (w_data[k+1])
        );
    end

    // Ready is a pure combinational chain from out_ready back to the input.
    assign in_ready          = Rst && w_ready[0];
    assign out_valid         = w_valid[DEPTH];
    assign w_out             = w_data[DEPTH];
    assign w_out_diff_unused = w_out.diff;
    assign diff              = w_out_diff_unused[DATAWIDTH-1:0];
    assign borrow            = w_out.borrow;
    assign ovf               = w_out.ovf;

endmodule

// File: tb/tb_sub_pipe.sv
// tb/tb_sub_pipe.sv - randomized and directed check of three sub_pipe configurations against an item-level model
module tb_sub_pipe;

    localparam int ST [3] = '{3, 2, 1};
    localparam int SG [3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       in_valid, out_ready;

    logic [7:0] o_diff [3];
    logic       o_inr  [3];
    logic       o_br   [3];
    logic       o_ov   [3];
    logic       o_vld  [3];

    always #5 clk = ~clk;

    sub_pipe #(.DATAWIDTH(8), .STAGES(3), .SIGNED(0)) u0 (
        .Clk(clk), .Rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(o_inr[0]),
        .diff(o_diff[0]), .borrow(o_br[0]), .ovf(o_ov[0]), .out_valid(o_vld[0]), .out_ready(out_ready));
    sub_pipe #(.DATAWIDTH(8), .STAGES(2), .SIGNED(1)) u1 (
        .Clk(clk), .Rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(o_inr[1]),
        .diff(o_diff[1]), .borrow(o_br[1]), .ovf(o_ov[1]), .out_valid(o_vld[1]), .out_ready(out_ready));
    sub_pipe #(.DATAWIDTH(8), .STAGES(1), .SIGNED(0)) u2 (
        .Clk(clk), .Rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(o_inr[2]),
        .diff(o_diff[2]), .borrow(o_br[2]), .ovf(o_ov[2]), .out_valid(o_vld[2]), .out_ready(out_ready));

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         pos;
    } item_t;

    // Per-instance queue of in-flight results, head first, each with its stage position.
    item_t mq [3][8];
    int    mn [3];
    bit    just_reset;
    int    checks;
    int    passed;

    task automatic check(input string tag, input int j, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s u%0d observed=%0h expected=%0h", tag, j, obs, exp);
    endtask

    function automatic item_t model(input int j, input logic [7:0] x, input logic [7:0] y);
        item_t r;
        int sa, sb, sd;
        r.d  = 8'(int'(x) - int'(y));
        r.br = (x < y);
        sa = int'(x);
        sb = int'(y);
        if (SG[j] != 0 && sa >= 128) sa -= 256;
        if (SG[j] != 0 && sb >= 128) sb -= 256;
        sd   = sa - sb;
        r.ov = (SG[j] != 0) && (sd > 127 || sd < -128);
`ifdef SUB_PIPE_SAT_EN
        if (SG[j] != 0 && r.ov) r.d = (sa >= 0) ? 8'h7F : 8'h80;
        else if (SG[j] == 0 && r.br) r.d = 8'h00;
`endif
        r.pos = 0;
        return r;
    endfunction

    function automatic logic exp_inr(input int j);
        return rst && (mn[j] < ST[j] || out_ready);
    endfunction

    task automatic compare_all();
        logic ev;
        for (int j = 0; j < 3; j++) begin
            check("in_ready", j, 8'(o_inr[j]), 8'(exp_inr(j)));
            ev = (mn[j] > 0) && (mq[j][0].pos == ST[j] - 1);
            check("out_valid", j, 8'(o_vld[j]), 8'(ev));
            if (ev) begin
                check("diff", j, o_diff[j], mq[j][0].d);
                check("borrow", j, 8'(o_br[j]), 8'(mq[j][0].br));
                check("ovf", j, 8'(o_ov[j]), 8'(mq[j][0].ov));
            end
            if (just_reset) begin
                check("rst_diff", j, o_diff[j], 8'h00);
                check("rst_borrow", j, 8'(o_br[j]), 8'h00);
                check("rst_ovf", j, 8'(o_ov[j]), 8'h00);
            end
        end
    endtask

    task automatic advance();
        bit acc, pop;
        int lim, np;
        for (int j = 0; j < 3; j++) begin
            if (!rst) begin
                mn[j] = 0;
            end else begin
                acc = in_valid && exp_inr(j);
                pop = (mn[j] > 0) && (mq[j][0].pos == ST[j] - 1) && out_ready;
                if (pop) begin
                    for (int i = 0; i < mn[j] - 1; i++) mq[j][i] = mq[j][i+1];
                    mn[j]--;
                end
                for (int i = 0; i < mn[j]; i++) begin
                    lim = (i == 0) ? ST[j] - 1 : mq[j][i-1].pos - 1;
                    np  = mq[j][i].pos + 1;
                    mq[j][i].pos = (np > lim) ? lim : np;
                end
                if (acc) begin
                    mq[j][mn[j]] = model(j, a, b);
                    mn[j]++;
                end
            end
        end
        just_reset = !rst;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic v, input logic r);
        a         = x;
        b         = y;
        in_valid  = v;
        out_ready = r;
        cycle();
    endtask

    initial begin
        checks = 0;
        passed = 0;
        just_reset = 0;
        for (int j = 0; j < 3; j++) mn[j] = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        cycle();
        cycle();
        rst = 1'b1;

        send(8'd200, 8'd55, 1, 1);
        send(8'd5,   8'd10, 1, 1);
        send(8'h80,  8'h01, 1, 1);
        send(8'h7F,  8'hFF, 1, 1);
        send(8'h00,  8'h00, 1, 1);
        send(8'hFF,  8'h00, 1, 1);
        send(8'h01,  8'h80, 1, 1);
        for (int c = 0; c < 5; c++) send(8'h00, 8'h00, 0, 1);

        // Ten pairs offered while the consumer stalls for cycles 4..8.
        for (int c = 0; c < 16; c++)
            send(8'($urandom), 8'($urandom), c < 10, !(c >= 4 && c <= 8));
        for (int c = 0; c < 5; c++) send(8'h00, 8'h00, 0, 1);

        // Continuous stream with a single stalled cycle in the middle.
        for (int c = 0; c < 12; c++)
            send(8'($urandom), 8'($urandom), 1, c != 6);
        for (int c = 0; c < 5; c++) send(8'h00, 8'h00, 0, 1);

        for (int c = 0; c < 300; c++)
            send(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        // Reset with results in flight; nothing stale may appear afterwards.
        send(8'd9, 8'd3, 1, 0);
        send(8'd7, 8'd8, 1, 0);
        rst = 1'b0;
        send(8'd1, 8'd2, 1, 1);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) send(8'h00, 8'h00, 0, 1);

        for (int c = 0; c < 60; c++)
            send(8'($urandom), 8'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 2) != 0);
        for (int c = 0; c < 10; c++) send(8'h00, 8'h00, 0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
